// File: rtl/host_seq_ctrl_pkg.sv
// Shared state encoding and SRAM geometry for the host-side sequencing controller.
package host_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_ACT,
    KICK,
    RUN,
    DRAIN,
    FINISH
  } host_seq_state_t;

  localparam int ID_W  = 32;
  localparam int WA_W  = 7;
  localparam int OA_W  = 9;
  localparam int OD_W  = 128;
  localparam int CNT_W = 10;

endpackage

// File: rtl/host_seq_ctrl_skid_fifo2.sv
// Two-entry FIFO that absorbs OP SRAM read data while the result stream is stalled.
module skid_fifo2
  import host_seq_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [OD_W-1:0] push_data,
  input  logic            pop,
  output logic [OD_W-1:0] head,
  output logic            full,
  output logic            empty,
  output logic [1:0]      count
);

  logic [OD_W-1:0] mem_q [2];
  logic [OD_W-1:0] mem_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/host_seq_ctrl.sv
// Host-side sequencer: loads W/ACT SRAMs, kicks the corelet, then drains the OP SRAM
// into a valid/ready result stream.
module host_seq_ctrl
  import host_seq_ctrl_pkg::*;
#(
  parameter int W_WORDS   = 72,
  parameter int ACT_WORDS = 36,
  parameter int OUT_WORDS = 16,
  parameter int OUT_BASE  = 0,
  parameter int TIMEOUT   = 4095
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  input  logic [ID_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [OD_W-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            seq_begin,
  input  logic            seq_done,
  output logic            sram_sel,
  output logic [ID_W-1:0] W_d,
  output logic [WA_W-1:0] W_addr,
  output logic            W_cen,
  output logic            W_wen,
  output logic [ID_W-1:0] ACT_d,
  output logic [WA_W-1:0] ACT_addr,
  output logic            ACT_cen,
  output logic            ACT_wen,
  input  logic [OD_W-1:0] OP_q,
  output logic [OA_W-1:0] OP_addr,
  output logic            OP_cen,
  output logic            OP_wen
);

  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  if (W_WORDS < 1 || W_WORDS > (1 << WA_W)) begin : g_w_words_check
    $error("host_seq_ctrl: W_WORDS must be within 1..128");
  end
  if (ACT_WORDS < 1 || ACT_WORDS > (1 << WA_W)) begin : g_act_words_check
    $error("host_seq_ctrl: ACT_WORDS must be within 1..128");
  end
  if (OUT_WORDS < 1 || OUT_BASE < 0 || OUT_BASE + OUT_WORDS > (1 << OA_W)) begin : g_out_range_check
    $error("host_seq_ctrl: OUT_BASE+OUT_WORDS must not exceed 512");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("host_seq_ctrl: TIMEOUT must be at least 1");
  end

  host_seq_state_t  state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;
  logic             seq_begin_q, seq_begin_d;
  logic             sram_sel_q, sram_sel_d;
  logic [ID_W-1:0]  w_data_q, w_data_d, act_data_q, act_data_d;
  logic [WA_W-1:0]  w_addr_q, w_addr_d, act_addr_q, act_addr_d;
  logic             w_cen_q, w_cen_d, w_wen_q, w_wen_d;
  logic             act_cen_q, act_cen_d, act_wen_q, act_wen_d;
  logic [OA_W-1:0]  op_addr_q, op_addr_d;
  logic             op_cen_q, op_cen_d;
  logic             rd_vld_q, rd_vld_d;

  logic             handshake;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]       fifo_count;
  logic [OD_W-1:0]  fifo_head;
  logic [2:0]       occupancy;

  skid_fifo2 u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (OP_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign handshake = in_valid && in_ready_q;
  assign fifo_push = rd_vld_q && !fifo_full;
  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  // Rows buffered plus reads on the SRAM port plus data returning this cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, ~op_cen_q} + {2'b00, rd_vld_q};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    timer_d    = timer_q;
    err_d      = err_q;
    w_data_d   = w_data_q;
    w_addr_d   = w_addr_q;
    w_cen_d    = 1'b1;
    w_wen_d    = 1'b1;
    act_data_d = act_data_q;
    act_addr_d = act_addr_q;
    act_cen_d  = 1'b1;
    act_wen_d  = 1'b1;
    op_addr_d  = op_addr_q;
    op_cen_d   = 1'b1;
    rd_vld_d   = ~op_cen_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      LOAD_W: begin
        if (handshake) begin
          w_cen_d  = 1'b0;
          w_wen_d  = 1'b0;
          w_addr_d = count_q[WA_W-1:0];
          w_data_d = in_data;
          if (count_q == CNT_W'(W_WORDS - 1)) begin
            state_d = LOAD_ACT;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      LOAD_ACT: begin
        if (handshake) begin
          act_cen_d  = 1'b0;
          act_wen_d  = 1'b0;
          act_addr_d = count_q[WA_W-1:0];
          act_data_d = in_data;
          if (count_q == CNT_W'(ACT_WORDS - 1)) begin
            state_d = KICK;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      KICK: begin
        state_d = RUN;
        timer_d = '0;
      end
      RUN: begin
        if (seq_done) begin
          state_d = DRAIN;
          count_d = '0;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          state_d = FINISH;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DRAIN: begin
        if (count_q < CNT_W'(OUT_WORDS) && occupancy < 3'd2) begin
          op_cen_d  = 1'b0;
          op_addr_d = OA_W'(OUT_BASE) + count_q[OA_W-1:0];
          count_d   = count_q + CNT_W'(1);
        end else if (count_q == CNT_W'(OUT_WORDS) && fifo_empty && op_cen_q && !rd_vld_q) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == LOAD_W) || (state_d == LOAD_ACT);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FINISH);
    seq_begin_d = (state_q == KICK);
    sram_sel_d  = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      seq_begin_q <= 1'b0;
      sram_sel_q  <= 1'b1;
      w_data_q    <= '0;
      w_addr_q    <= '0;
      w_cen_q     <= 1'b1;
      w_wen_q     <= 1'b1;
      act_data_q  <= '0;
      act_addr_q  <= '0;
      act_cen_q   <= 1'b1;
      act_wen_q   <= 1'b1;
      op_addr_q   <= '0;
      op_cen_q    <= 1'b1;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      seq_begin_q <= seq_begin_d;
      sram_sel_q  <= sram_sel_d;
      w_data_q    <= w_data_d;
      w_addr_q    <= w_addr_d;
      w_cen_q     <= w_cen_d;
      w_wen_q     <= w_wen_d;
      act_data_q  <= act_data_d;
      act_addr_q  <= act_addr_d;
      act_cen_q   <= act_cen_d;
      act_wen_q   <= act_wen_d;
      op_addr_q   <= op_addr_d;
      op_cen_q    <= op_cen_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign in_ready  = in_ready_q;
  assign out_data  = fifo_head;
  assign seq_begin = seq_begin_q;
  assign sram_sel  = sram_sel_q;
  assign W_d       = w_data_q;
  assign W_addr    = w_addr_q;
  assign W_cen     = w_cen_q;
  assign W_wen     = w_wen_q;
  assign ACT_d     = act_data_q;
  assign ACT_addr  = act_addr_q;
  assign ACT_cen   = act_cen_q;
  assign ACT_wen   = act_wen_q;
  assign OP_addr   = op_addr_q;
  assign OP_cen    = op_cen_q;
  assign OP_wen    = 1'b1;

endmodule

// File: tb/tb_host_seq_ctrl.sv
// Directed bench for host_seq_ctrl: load, kick, drain, backpressure, timeout and mid-run reset.
module tb_host_seq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared stimulus
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;

  // Main instance (default parameters)
  logic         start = 1'b0, in_valid = 1'b0, seq_done = 1'b0;
  logic         busy, done, err, in_ready, out_valid, seq_begin, sram_sel;
  logic [127:0] out_data;
  logic [31:0]  W_d, ACT_d;
  logic [6:0]   W_addr, ACT_addr;
  logic         W_cen, W_wen, ACT_cen, ACT_wen, OP_cen, OP_wen;
  logic [8:0]   OP_addr;
  logic [127:0] OP_q = '0;

  // Short-timeout instance
  logic         start_to = 1'b0, in_valid_to = 1'b0, seq_done_to = 1'b0;
  logic         busy_to, done_to, err_to, in_ready_to, out_valid_to, seq_begin_to, sram_sel_to;
  logic [127:0] out_data_to;
  logic [31:0]  W_d_to, ACT_d_to;
  logic [6:0]   W_addr_to, ACT_addr_to;
  logic         W_cen_to, W_wen_to, ACT_cen_to, ACT_wen_to, OP_cen_to, OP_wen_to;
  logic [8:0]   OP_addr_to;
  logic [127:0] OP_q_to = '0;

  host_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .seq_begin(seq_begin), .seq_done(seq_done), .sram_sel(sram_sel),
    .W_d(W_d), .W_addr(W_addr), .W_cen(W_cen), .W_wen(W_wen),
    .ACT_d(ACT_d), .ACT_addr(ACT_addr), .ACT_cen(ACT_cen), .ACT_wen(ACT_wen),
    .OP_q(OP_q), .OP_addr(OP_addr), .OP_cen(OP_cen), .OP_wen(OP_wen)
  );

  host_seq_ctrl #(.W_WORDS(4), .ACT_WORDS(2), .OUT_WORDS(2), .OUT_BASE(0), .TIMEOUT(20)) dut_to (
    .clk(clk), .reset(reset), .start(start_to), .busy(busy_to), .done(done_to), .err(err_to),
    .in_data(in_data), .in_valid(in_valid_to), .in_ready(in_ready_to),
    .out_data(out_data_to), .out_valid(out_valid_to), .out_ready(out_ready),
    .seq_begin(seq_begin_to), .seq_done(seq_done_to), .sram_sel(sram_sel_to),
    .W_d(W_d_to), .W_addr(W_addr_to), .W_cen(W_cen_to), .W_wen(W_wen_to),
    .ACT_d(ACT_d_to), .ACT_addr(ACT_addr_to), .ACT_cen(ACT_cen_to), .ACT_wen(ACT_wen_to),
    .OP_q(OP_q_to), .OP_addr(OP_addr_to), .OP_cen(OP_cen_to), .OP_wen(OP_wen_to)
  );

  // OP SRAM models: each row holds its own address, data one cycle after the read.
  always @(posedge clk) if (!OP_cen) OP_q <= 128'(OP_addr);
  always @(posedge clk) if (!OP_cen_to) OP_q_to <= 128'(OP_addr_to);

  // Monitors sample on the falling edge, away from the active edge.
  logic [31:0]  w_mem [128];
  logic [31:0]  act_mem [128];
  logic [127:0] rows [$];
  int w_writes, act_writes, sb_count, sb_cyc, last_act_cyc, reads, pops, pop_cyc, max_out, done_count, done_cyc;
  int sb_to_cyc, done_to_count, done_to_cyc, reads_to;
  logic err_at_done;

  always @(negedge clk) begin
    if (!reset) begin
      if (!W_cen && !W_wen) begin w_mem[W_addr] = W_d; w_writes++; end
      if (!ACT_cen && !ACT_wen) begin act_mem[ACT_addr] = ACT_d; act_writes++; last_act_cyc = cyc; end
      if (seq_begin) begin sb_count++; sb_cyc = cyc; end
      if (!OP_cen) reads++;
      if (reads - pops > max_out) max_out = reads - pops;
      if (out_valid && out_ready) begin rows.push_back(out_data); pops++; pop_cyc = cyc; end
      if (done) begin done_count++; done_cyc = cyc; end
      if (seq_begin_to) sb_to_cyc = cyc;
      if (!OP_cen_to) reads_to++;
      if (done_to) begin done_to_count++; done_to_cyc = cyc; err_at_done = err_to; end
    end
  end

  task automatic clear_mon();
    for (int i = 0; i < 128; i++) begin w_mem[i] = 32'hdeadbeef; act_mem[i] = 32'hdeadbeef; end
    rows.delete();
    w_writes = 0; act_writes = 0; sb_count = 0; sb_cyc = -1; last_act_cyc = -1;
    reads = 0; pops = 0; pop_cyc = -1; max_out = 0; done_count = 0; done_cyc = -1;
    sb_to_cyc = -1; done_to_count = 0; done_to_cyc = -1; reads_to = 0; err_at_done = 1'b0;
  endtask

  task automatic pulse_start(input bit to_dut);
    @(posedge clk); #1;
    if (to_dut) start_to = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_to = 1'b0;
  endtask

  task automatic pulse_seq_done();
    @(posedge clk); #1; seq_done = 1'b1;
    @(posedge clk); #1; seq_done = 1'b0;
  endtask

  task automatic drive_load(input bit to_dut, input bit stall, input int n);
    int i = 0;
    int spent = 0;
    bit ph = 1'b1;
    bit hs;
    while (i < n && spent < 4 * n + 20) begin
      in_data = 32'(i);
      if (to_dut) in_valid_to = ph | ~stall; else in_valid = ph | ~stall;
      @(negedge clk);
      hs = to_dut ? (in_valid_to && in_ready_to) : (in_valid && in_ready);
      @(posedge clk); #1;
      if (hs) i++;
      ph = ~ph;
      spent++;
    end
    in_valid = 1'b0; in_valid_to = 1'b0;
    checks++;
    if (i != n) begin errors++; $display("[TB] FAIL load_accept: accepted %0d words, expected %0d", i, n); end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_count == 0 && n < budget) begin @(negedge clk); #1; n++; end
    checks++;
    if (done_count != 1) begin errors++; $display("[TB] FAIL done_pulse: saw %0d done pulses, expected 1", done_count); end
  endtask

  task automatic check_load_contents(input string tag);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 72; i++) if (w_mem[i] !== 32'(i)) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL %s_w_mem: %0d wrong words, first addr %0d got %h expected %h", tag, bad, first, w_mem[first], 32'(first)); end
    bad = 0; first = -1;
    for (int i = 0; i < 36; i++) if (act_mem[i] !== 32'(i + 72)) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL %s_act_mem: %0d wrong words, first addr %0d got %h expected %h", tag, bad, first, act_mem[first], 32'(first + 72)); end
    checks++;
    if (w_writes != 72 || act_writes != 36) begin errors++; $display("[TB] FAIL %s_write_count: got W=%0d ACT=%0d expected W=72 ACT=36", tag, w_writes, act_writes); end
  endtask

  task automatic check_rows(input string tag);
    checks++;
    if (rows.size() != 16) begin errors++; $display("[TB] FAIL %s_row_count: got %0d rows expected 16", tag, rows.size()); end
    for (int i = 0; i < rows.size() && i < 16; i++) begin
      checks++;
      if (rows[i] !== 128'(i)) begin errors++; $display("[TB] FAIL %s_row%0d: got %0h expected %0h", tag, i, rows[i], 128'(i)); end
    end
  endtask

  task automatic test_reset();
    clear_mon();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, err, in_ready, out_valid, seq_begin} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_status: got %b expected 000000", {busy, done, err, in_ready, out_valid, seq_begin});
    end
    checks++;
    if ({sram_sel, W_cen, W_wen, ACT_cen, ACT_wen, OP_cen, OP_wen} !== 7'h7f) begin
      errors++; $display("[TB] FAIL reset_sram_ctl: got %b expected 1111111", {sram_sel, W_cen, W_wen, ACT_cen, ACT_wen, OP_cen, OP_wen});
    end
    checks++;
    if ({W_addr, ACT_addr, OP_addr, W_d, ACT_d} !== '0) begin
      errors++; $display("[TB] FAIL reset_addr_data: got W_addr=%0d ACT_addr=%0d OP_addr=%0d W_d=%h ACT_d=%h expected all 0", W_addr, ACT_addr, OP_addr, W_d, ACT_d);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_basic_load();
    clear_mon();
    pulse_start(1'b0);
    drive_load(1'b0, 1'b0, 108);
    repeat (3) begin @(negedge clk); #1; end
    check_load_contents("basic");
    checks++;
    if (sb_count != 1) begin errors++; $display("[TB] FAIL basic_seq_begin_count: got %0d expected 1", sb_count); end
    checks++;
    if (sb_cyc != last_act_cyc + 1) begin errors++; $display("[TB] FAIL basic_seq_begin_timing: got cycle %0d expected %0d", sb_cyc, last_act_cyc + 1); end
    checks++;
    if ({busy, sram_sel, in_ready} !== 3'b100) begin errors++; $display("[TB] FAIL basic_run_status: got busy/sram_sel/in_ready=%b expected 100", {busy, sram_sel, in_ready}); end
  endtask

  task automatic test_drain_ready();
    out_ready = 1'b1;
    repeat (195) @(posedge clk);
    pulse_seq_done();
    wait_done(500);
    check_rows("drain");
    checks++;
    if (done_cyc <= pop_cyc) begin errors++; $display("[TB] FAIL drain_done_order: done at cycle %0d, last pop at %0d", done_cyc, pop_cyc); end
    @(negedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL drain_busy_fall: got busy/done=%b expected 00", {busy, done}); end
  endtask

  task automatic test_load_stall();
    clear_mon();
    pulse_start(1'b0);
    drive_load(1'b0, 1'b1, 108);
    repeat (3) begin @(negedge clk); #1; end
    check_load_contents("stall");
    checks++;
    if (sb_count != 1) begin errors++; $display("[TB] FAIL stall_seq_begin_count: got %0d expected 1", sb_count); end
  endtask

  task automatic test_backpressure();
    int held = 0;
    int n = 0;
    out_ready = 1'b1;
    pulse_seq_done();
    while (done_count == 0 && n < 3000) begin
      if (pops >= 3 && held < 5) begin out_ready = 1'b0; held++; end
      else if (held >= 5) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    checks++;
    if (done_count != 1) begin errors++; $display("[TB] FAIL bp_done_pulse: saw %0d done pulses, expected 1", done_count); end
    check_rows("bp");
    checks++;
    if (max_out > 2) begin errors++; $display("[TB] FAIL bp_outstanding: got max %0d expected at most 2", max_out); end
    checks++;
    if (reads != 16) begin errors++; $display("[TB] FAIL bp_read_count: got %0d reads expected 16", reads); end
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_mon();
    pulse_start(1'b1);
    drive_load(1'b1, 1'b0, 6);
    while (done_to_count == 0 && n < 100) begin @(negedge clk); #1; n++; end
    checks++;
    if (done_to_count != 1) begin errors++; $display("[TB] FAIL timeout_done: saw %0d done pulses, expected 1", done_to_count); end
    checks++;
    if (err_at_done !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", err_at_done); end
    checks++;
    if (done_to_cyc - sb_to_cyc != 21) begin errors++; $display("[TB] FAIL timeout_latency: got %0d cycles expected 21", done_to_cyc - sb_to_cyc); end
    checks++;
    if (reads_to != 0) begin errors++; $display("[TB] FAIL timeout_no_reads: got %0d reads expected 0", reads_to); end
    @(negedge clk); #1;
    checks++;
    if ({busy_to, err_to} !== 2'b01) begin errors++; $display("[TB] FAIL timeout_idle: got busy/err=%b expected 01", {busy_to, err_to}); end
    pulse_start(1'b1);
    checks++;
    if ({err_to, busy_to} !== 2'b01) begin errors++; $display("[TB] FAIL timeout_err_clear: got err/busy=%b expected 01", {err_to, busy_to}); end
  endtask

  task automatic test_mid_run_reset();
    int n = 0;
    int sb_before;
    clear_mon();
    pulse_start(1'b0);
    drive_load(1'b0, 1'b0, 108);
    repeat (5) @(posedge clk);
    out_ready = 1'b1;
    pulse_seq_done();
    while (pops < 7 && n < 200) begin @(negedge clk); #1; n++; end
    checks++;
    if (pops != 7) begin errors++; $display("[TB] FAIL midreset_reach_row7: got %0d pops expected 7", pops); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, err, in_ready, out_valid, seq_begin} !== 6'b0) begin
      errors++; $display("[TB] FAIL midreset_status: got %b expected 000000", {busy, done, err, in_ready, out_valid, seq_begin});
    end
    checks++;
    if ({sram_sel, W_cen, W_wen, ACT_cen, ACT_wen, OP_cen, OP_wen} !== 7'h7f) begin
      errors++; $display("[TB] FAIL midreset_sram_ctl: got %b expected 1111111", {sram_sel, W_cen, W_wen, ACT_cen, ACT_wen, OP_cen, OP_wen});
    end
    checks++;
    if ({W_addr, ACT_addr, OP_addr, W_d, ACT_d} !== '0) begin
      errors++; $display("[TB] FAIL midreset_addr_data: got W_addr=%0d ACT_addr=%0d OP_addr=%0d W_d=%h ACT_d=%h expected all 0", W_addr, ACT_addr, OP_addr, W_d, ACT_d);
    end
    #1 reset = 1'b0;
    sb_before = sb_count;
    repeat (5) begin @(negedge clk); #1; end
    checks++;
    if (sb_count != sb_before || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_quiet: got seq_begin pulses=%0d busy=%b out_valid=%b expected 0/0/0", sb_count - sb_before, busy, out_valid);
    end
    clear_mon();
    pulse_start(1'b0);
    drive_load(1'b0, 1'b0, 108);
    repeat (10) @(posedge clk);
    pulse_seq_done();
    wait_done(500);
    check_rows("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_drain_ready();
    test_load_stall();
    test_backpressure();
    test_timeout();
    test_mid_run_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_seq_ctrl.md
Name: host_seq_ctrl

Overview:
- Host-side counterpart of the corelet sequencing interface.
- Fills the weight and activation SRAMs from an input word stream, then pulses seq_begin and waits for seq_done.
- After seq_done, reads the output SRAM and streams its rows out with valid/ready backpressure.
- Sits beside the corelet in the top level and owns the SRAM ports whenever sram_sel=1.

Parameters:
- W_WORDS, 72, 32-bit weight words written (9 kij x 8 rows)
- ACT_WORDS, 36, 32-bit activation words written
- OUT_WORDS, 16, 128-bit output rows read back
- OUT_BASE, 0, first OP SRAM address read
- TIMEOUT, 4095, maximum RUN cycles before abort

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin a job (sampled in IDLE only)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  set on timeout; cleared on next accepted start
- in_data  in  32  load stream data
- in_valid  in  1  load stream valid
- in_ready  out  1  load stream ready
- out_data  out  128  result stream data
- out_valid  out  1  result stream valid
- out_ready  in  1  result stream ready
- seq_begin  out  1  to corelet; one-cycle pulse
- seq_done  in  1  from corelet
- sram_sel  out  1  1 = this block drives the SRAM ports; 0 = corelet drives them
- W_d  out  32  weight SRAM write data
- W_addr  out  7  weight SRAM address
- W_cen  out  1  weight SRAM chip enable, active low
- W_wen  out  1  weight SRAM write enable, active low
- ACT_d  out  32  activation SRAM write data
- ACT_addr  out  7  activation SRAM address
- ACT_cen  out  1  activation SRAM chip enable, active low
- ACT_wen  out  1  activation SRAM write enable, active low
- OP_q  in  128  output SRAM read data, valid the cycle after the read
- OP_addr  out  9  output SRAM address
- OP_cen  out  1  output SRAM chip enable, active low
- OP_wen  out  1  output SRAM write enable, active low; always 1

Behaviour:
- Reset values:
  - state=IDLE, all counters 0.
  - busy=0, done=0, err=0, in_ready=0, out_valid=0, seq_begin=0.
  - sram_sel=1, all cen/wen=1, all addr/d=0, skid buffer empty.
- States: IDLE, LOAD_W, LOAD_ACT, KICK, RUN, DRAIN, FINISH.
- IDLE:
  - start=1 -> LOAD_W; clear count and err.
  - start in any other state is ignored.
- LOAD_W:
  - in_ready=1. Each handshake (in_valid & in_ready) registers a write.
  - The write is issued the next cycle: W_cen=0, W_wen=0, W_addr=count, W_d=in_data; count+1.
  - Handshake with count==W_WORDS-1 -> LOAD_ACT, count=0.
- LOAD_ACT:
  - Same as LOAD_W, but writes to the ACT SRAM.
  - Last handshake (count==ACT_WORDS-1) -> KICK.
- KICK (1 cycle):
  - The final ACT write completes in this cycle.
  - in_ready=0, sram_sel=1, seq_begin=1 -> RUN.
- RUN:
  - sram_sel=0; all host cen/wen=1; timer counts up.
  - seq_done=1 -> DRAIN, count=0.
  - timer==TIMEOUT with no seq_done -> err=1, FINISH.
  - seq_done seen in any state other than RUN is ignored.
- DRAIN:
  - sram_sel=1.
  - Issue a read (OP_cen=0, OP_addr=OUT_BASE+count) only when skid occupancy + in-flight reads < 2.
  - Data returns one cycle later and is pushed into the skid buffer.
  - out_valid = buffer not empty; pop on out_valid & out_ready.
  - After OUT_WORDS reads are issued and the buffer is empty -> FINISH.
  - out_valid held low with out_ready=1 never loses or duplicates a row; order is preserved.
- FINISH: done=1 for one cycle -> IDLE.
- Load stream stalls: in_valid=0 in LOAD states holds count; there is no timeout during load.
- Address widths: W_addr and ACT_addr are the low 7 bits of count; OP_addr is a 9-bit sum. Parameters must keep addresses in range: elaboration-time assertion on W_WORDS ≤ 128, ACT_WORDS ≤ 128, OUT_BASE+OUT_WORDS ≤ 512.
- Reset mid-operation:
  - Immediate return to the reset values on the next clock.
  - In-flight reads and buffered rows are discarded; seq_begin is not re-issued.

Decomposition:
- Shared package: state enum host_seq_state_t, SRAM width constants (7-bit ACT/W address, 9-bit OP address, 128-bit OP data).
- Sub-module skid_fifo2: 2-entry 128-bit FIFO with push, pop, full, empty and count, same clock and reset.

Test Plan:
- Basic load:
  - Stimulus: start, stream words 0..107 with continuous valid.
  - Required: W SRAM addresses 0..71 hold 0..71; ACT addresses 0..35 hold 72..107; exactly one seq_begin pulse, one cycle after the last ACT write is issued.
- Load stall:
  - Stimulus: in_valid toggling 1010...
  - Required: same SRAM contents as the basic load; no write issued on a non-handshake cycle.
- Drain with continuous ready:
  - Stimulus: seq_done after 200 cycles; OP SRAM model returns the address value; out_ready=1.
  - Required: 16 rows with values 0..15 in order; done pulse after the last pop; busy falls with it.
- Drain backpressure:
  - Stimulus: out_ready low for 5 cycles at row 3, then random.
  - Required: rows 0..15 exactly once, in order; never more than 2 reads outstanding or buffered.
- Timeout:
  - Stimulus: TIMEOUT=20, seq_done never asserted.
  - Required: err=1, done pulse, return to IDLE, no OP reads; the next start clears err.
- Mid-run reset:
  - Stimulus: reset during DRAIN at row 7.
  - Required: all outputs return to reset values the next cycle; a new job then completes normally.
